// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: picks one valid channel per cycle (round-robin
// or fixed priority) and captures its word and index into an output register.
module rr_arb_mux #(
    parameter int WIDTH     = 32,
    parameter int N         = 2,
    parameter bit FIXED_PRI = 1'b0,
    localparam int SEL_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_sel_q,    out_sel_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] search_idx;
    logic [WIDTH-1:0] chan_data [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi]  = grant_valid && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    assign load_en = !out_valid_q || out_ready;

    // Scan from the lowest-priority candidate up so the last hit is the winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        if (load_en && !rst) begin
            if (FIXED_PRI) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SEL_W'(i);
                    end
                end
            end else begin
                for (int k = N; k >= 1; k--) begin
                    search_idx = SEL_W'((int'(last_grant_q) + k) % N);
                    if (in_valid[search_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = search_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (grant_valid) begin
                out_data_d   = chan_data[grant_idx];
                out_sel_d    = grant_idx;
                out_valid_d  = 1'b1;
                last_grant_d = grant_idx;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    // last_grant resets to N-1 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SEL_W'(N - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin and a fixed-priority instance (N=4)
// share stimulus; each task checks its scenario against hand-computed values.
module tb_rr_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   word [N];
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready, fp_in_ready;
    logic [W-1:0]   rr_out_data, fp_out_data;
    logic [1:0]     rr_out_sel,  fp_out_sel;
    logic           rr_out_valid, fp_out_valid;

    int checks = 0;
    int errors = 0;

    assign in_data = {word[3], word[2], word[1], word[0]};

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(W), .N(N), .FIXED_PRI(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_valid(rr_out_valid), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(N), .FIXED_PRI(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_valid(fp_out_valid), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words();
        word[0] = 32'hA000_0000;
        word[1] = 32'hB111_1111;
        word[2] = 32'hC222_2222;
        word[3] = 32'hD333_3333;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_words();
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rr_out_valid); end
        checks++;
        if (rr_out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rr_out_data); end
        checks++;
        if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", rr_in_ready); end
        checks++;
        if (fp_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_fp_in_ready got %b want 0000", fp_in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready got %b want 0001", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_sel !== 2'd0 || rr_out_valid !== 1'b1 || rr_out_data !== word[0]) begin
            errors++;
            $display("FAIL reset_first_grant got sel=%0d v=%b d=%h want sel=0 v=1 d=%h",
                     rr_out_sel, rr_out_valid, rr_out_data, word[0]);
        end
        $display("reset: first grant sel=%0d data=%h", rr_out_sel, rr_out_data);
    endtask

    task automatic test_rr();
        logic [1:0] exp_sel;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_sel = 2'(i % 4);
            tick();
            checks++;
            if (rr_out_sel !== exp_sel || rr_out_data !== word[exp_sel] || rr_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq[%0d] got sel=%0d d=%h v=%b want sel=%0d d=%h v=1",
                         i, rr_out_sel, rr_out_data, rr_out_valid, exp_sel, word[exp_sel]);
            end
            $display("rr: cycle %0d sel=%0d data=%h", i, rr_out_sel, rr_out_data);
        end
    endtask

    task automatic test_stall();
        do_reset();
        word[0]   = 32'hDEAD_BEEF;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", i, rr_in_ready); end
            checks++;
            if (rr_out_data !== 32'hDEAD_BEEF || rr_out_sel !== 2'd0 || rr_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d] got d=%h sel=%0d v=%b want d=deadbeef sel=0 v=1",
                         i, rr_out_data, rr_out_sel, rr_out_valid);
            end
            $display("stall: cycle %0d data=%h", i, rr_out_data);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0010) begin errors++; $display("FAIL stall_release_ready got %b want 0010", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_data !== word[1] || rr_out_sel !== 2'd1 || rr_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_reload got d=%h sel=%0d v=%b want d=%h sel=1 v=1",
                     rr_out_data, rr_out_sel, rr_out_valid, word[1]);
        end
        in_valid = 4'b0000;
        tick();
        checks++;
        if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got v=%b want 0", rr_out_valid); end
        set_words();
    endtask

    task automatic test_sparse();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        tick();
        in_valid = 4'b0001;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL sparse_wrap_ready got %b want 0001", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_sel !== 2'd0 || rr_out_data !== word[0]) begin
            errors++;
            $display("FAIL sparse_wrap got sel=%0d d=%h want sel=0 d=%h", rr_out_sel, rr_out_data, word[0]);
        end
        in_valid = 4'b0101;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0100) begin errors++; $display("FAIL sparse_next_ready got %b want 0100", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_sel !== 2'd2 || rr_out_data !== word[2]) begin
            errors++;
            $display("FAIL sparse_next got sel=%0d d=%h want sel=2 d=%h", rr_out_sel, rr_out_data, word[2]);
        end
        $display("sparse: wrap then sel=%0d", rr_out_sel);
    endtask

    task automatic test_fixed();
        logic [1:0] rr_exp;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            rr_exp = 2'(1 + (i % 3));
            #1;
            checks++;
            if (fp_in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready[%0d] got %b want 0010", i, fp_in_ready); end
            tick();
            checks++;
            if (fp_out_sel !== 2'd1 || fp_out_data !== word[1] || fp_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fixed_sel[%0d] got sel=%0d d=%h v=%b want sel=1 d=%h v=1",
                         i, fp_out_sel, fp_out_data, fp_out_valid, word[1]);
            end
            checks++;
            if (rr_out_sel !== rr_exp) begin
                errors++;
                $display("FAIL fixed_rr_cmp[%0d] got sel=%0d want %0d", i, rr_out_sel, rr_exp);
            end
            $display("fixed: cycle %0d fp_sel=%0d rr_sel=%0d", i, fp_out_sel, rr_out_sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        checks++;
        if (rr_out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got v=%b want 1", rr_out_valid); end
        in_valid = 4'b0011;
        rst      = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_dropped got v=%b d=%h want v=0 d=0", rr_out_valid, rr_out_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_ready got %b want 0001", rr_in_ready); end
        tick();
        checks++;
        if (rr_out_sel !== 2'd0 || rr_out_valid !== 1'b1 || rr_out_data !== word[0]) begin
            errors++;
            $display("FAIL mid_after_grant got sel=%0d v=%b d=%h want sel=0 v=1 d=%h",
                     rr_out_sel, rr_out_valid, rr_out_data, word[0]);
        end
        $display("reset_mid: after release sel=%0d", rr_out_sel);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        set_words();
        test_reset();
        test_rr();
        test_stall();
        test_sparse();
        test_fixed();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
